note_voice_scheduler: RTL and testbench
=======================================

# note_voice_scheduler

Multi-voice square-wave tone scheduler that owns the single 128-entry note-period ROM (16-bit half-period values in 100 kHz ticks, addressed by MIDI note number, one-cycle synchronous read). It accepts note-on/note-off commands from the sequencer over a valid/ready port, runs one ROM lookup per note-on, and loads the result into that voice's half-period register. It runs one free-running half-period counter per voice and emits per-voice square waves plus a registered mix count for the PWM audio DAC.

## Interface
- VOICES, 4, number of voices; power of two, at least 2
- TICK_DIV, 270, clk cycles per 100 kHz tick (270 at 27 MHz); at least 2
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- req_valid  in  1  command valid
- req_ready  out  1  command accepted when req_valid && req_ready
- req_on  in  1  1 = note-on, 0 = note-off
- req_voice  in  log2(VOICES)  target voice
- req_note  in  7  MIDI note number, used only for note-on
- rom_ce  out  1  ROM clock enable
- rom_oce  out  1  ROM output enable, equal to rom_ce
- rom_ad  out  7  ROM address
- rom_dout  in  16  ROM data, valid the cycle after rom_ce is sampled high
- wave  out  VOICES  per-voice square wave
- voice_active  out  VOICES  voice is sounding
- mix  out  log2(VOICES)+1  registered count of wave bits that are high

## Operation
- FSM states are IDLE, READ and LOAD. req_ready = (state==IDLE) && !reset.
- IDLE, note-off accepted: on that edge, clear voice_active[v], force wave[v]=0 and clear cnt[v]. The FSM stays in IDLE, so back-to-back note-offs are accepted every cycle.
- IDLE, note-on accepted: latch voice and note, then go to READ.
- READ: rom_ce=rom_oce=1 and rom_ad=latched note, then go to LOAD.
- LOAD: rom_ce=0. On the edge, write per[v]=rom_dout and cnt[v]=rom_dout, force wave[v]=0, set voice_active[v]=(rom_dout!=0), then go to IDLE.
- Tick generator: a counter runs 0..TICK_DIV-1 and `tick` is high for one cycle when it wraps. The counter runs from reset regardless of voice state.
- Per-voice update on tick when active:
  - if cnt<=1: cnt<=per and wave toggles
  - else: cnt<=cnt-1
- Inactive voices hold cnt=0 and wave=0.
- Counters are 16-bit unsigned. The half-period equals per ticks, so f = 100 kHz / (2·per).
- mix <= popcount(wave) every cycle. mix lags wave by one cycle.

## Timing
- Reset values: req_ready=0 during reset; rom_ce=0, rom_oce=0, rom_ad=0, wave=0, voice_active=0, mix=0; all per and cnt are 0; tick counter is 0; state is IDLE.
- After reset deasserts, req_ready=1 in the first cycle.
- Note-on accepted at edge N:
  - rom_ce=1 during cycle N+1
  - rom_dout is sampled at edge N+2, where voice state updates
  - req_ready returns to 1 in cycle N+2
  - throughput is one note-on per 3 cycles
- Note-off takes effect at the accept edge. Throughput is 1 per cycle.
- Tick and LOAD hit the same voice on the same edge: LOAD wins and the tick is discarded for that voice. Other voices tick normally.
- Note-on to an already active voice (retrigger) reloads per and cnt and restarts the phase low.
- Note-off to an inactive voice has no effect beyond holding state cleared.
- A note-off for the voice currently being looked up can only arrive in IDLE, so it cannot collide with that lookup.
- Reset during READ or LOAD abandons the lookup. No voice is updated and rom_ce drops on the reset edge.
- rom_ad holds its last value outside READ.
- Commands presented while reset=1 are ignored.

## Test plan
- Reset check, TICK_DIV=4: hold reset 3 cycles with req_valid=1. Require no accept, all outputs 0 and req_ready=0. In the first cycle after release, require req_ready=1.
- Note-on, voice 1, note 69, with a ROM model loaded from the production table:
  - require rom_ce=1 and rom_ad=69 one cycle after accept
  - require per[1]=0x0072 (114)
  - require wave[1] to toggle every 114 ticks (456 clk), giving a 912-clk period
  - require voice_active=4'b0010
- Table extremes: note 0 gives a half-period of 0x17E4 (6116 ticks). Note 127 gives 4 ticks, so wave toggles every 16 clk at TICK_DIV=4.
- Four voices, notes 60/64/67/72 issued back to back:
  - require req_ready low for exactly 2 cycles after each accept
  - require all four voices active, each toggling at its table period
  - require mix to track popcount(wave) with one-cycle lag
- Note-off on voice 2 mid-tone: wave[2]=0 and voice_active[2]=0 on the accept edge. Require a second note-off in the next cycle to be accepted.
- Collision and abort:
  - force LOAD on the tick edge for an active voice: require cnt = new per and wave=0, with the tick ignored
  - assert reset during READ: require no per or voice_active change and rom_ce=0 the next cycle

Source files
------------

// File: rtl/note_voice_scheduler.sv
// Multi-voice square-wave tone scheduler: one shared note-period ROM lookup per note-on,
// a free-running 100 kHz tick, and a per-voice half-period counter driving each square wave.

module note_voice_lane (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic        load,
  input  logic        off,
  input  logic [15:0] load_val,
  output logic        wave,
  output logic        active,
  output logic [15:0] per,
  output logic [15:0] cnt
);
  // A load outranks a same-edge tick, so a retrigger always restarts the phase cleanly.
  always_ff @(posedge clk) begin
    if (reset) begin
      wave   <= 1'b0;
      active <= 1'b0;
      per    <= '0;
      cnt    <= '0;
    end else if (load) begin
      per    <= load_val;
      cnt    <= load_val;
      wave   <= 1'b0;
      active <= (load_val != 16'd0);
    end else if (off) begin
      active <= 1'b0;
      wave   <= 1'b0;
      cnt    <= '0;
    end else if (tick && active) begin
      if (cnt <= 16'd1) begin
        cnt  <= per;
        wave <= ~wave;
      end else begin
        cnt <= cnt - 16'd1;
      end
    end
  end
endmodule

module note_voice_scheduler #(
  parameter  int VOICES   = 4,
  parameter  int TICK_DIV = 270,
  localparam int VW       = $clog2(VOICES),
  localparam int MW       = VW + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_on,
  input  logic [VW-1:0]     req_voice,
  input  logic [6:0]        req_note,
  output logic              rom_ce,
  output logic              rom_oce,
  output logic [6:0]        rom_ad,
  input  logic [15:0]       rom_dout,
  output logic [VOICES-1:0] wave,
  output logic [VOICES-1:0] voice_active,
  output logic [MW-1:0]     mix
);
  localparam int TW = $clog2(TICK_DIV);

  typedef enum logic [1:0] {IDLE, READ, LOAD} state_t;
  typedef struct packed {
    logic [VW-1:0] voice;
    logic [6:0]    note;
  } cmd_t;

  state_t                   state;
  cmd_t                     lat;
  logic [TW-1:0]            tick_cnt;
  logic                     tick;
  logic                     accept;
  logic [VOICES-1:0]        load_vec;
  logic [VOICES-1:0]        off_vec;
  logic [VOICES-1:0][15:0]  per;
  logic [VOICES-1:0][15:0]  cnt;
  logic [MW-1:0]            pop;

  assign req_ready = (state == IDLE) && !reset;
  assign accept    = req_valid && req_ready;
  assign rom_oce   = rom_ce;
  // The latched note doubles as the ROM address, so it holds outside READ.
  assign rom_ad    = lat.note;
  assign tick      = (tick_cnt == TW'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (reset || tick) tick_cnt <= '0;
    else               tick_cnt <= tick_cnt + TW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      rom_ce <= 1'b0;
      lat    <= '0;
    end else begin
      case (state)
        IDLE: if (accept && req_on) begin
          lat    <= '{voice: req_voice, note: req_note};
          rom_ce <= 1'b1;
          state  <= READ;
        end
        READ: begin
          rom_ce <= 1'b0;
          state  <= LOAD;
        end
        LOAD:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    load_vec = '0;
    off_vec  = '0;
    for (int i = 0; i < VOICES; i++) begin
      load_vec[i] = (state == LOAD) && (lat.voice == VW'(i));
      off_vec[i]  = accept && !req_on && (req_voice == VW'(i));
    end
  end

  for (genvar g = 0; g < VOICES; g++) begin : g_lane
    note_voice_lane u_lane (
      .clk      (clk),
      .reset    (reset),
      .tick     (tick),
      .load     (load_vec[g]),
      .off      (off_vec[g]),
      .load_val (rom_dout),
      .wave     (wave[g]),
      .active   (voice_active[g]),
      .per      (per[g]),
      .cnt      (cnt[g])
    );
  end

  always_comb begin
    pop = '0;
    for (int i = 0; i < VOICES; i++) pop = pop + MW'(wave[i]);
  end

  always_ff @(posedge clk) begin
    if (reset) mix <= '0;
    else       mix <= pop;
  end
endmodule

// File: tb/tb_note_voice_scheduler.sv
// Directed bench for note_voice_scheduler: vector table for the command/handshake flow,
// hand sequences for tone periods, note-off, tick/LOAD collision and reset abort.

module tb_note_voice_scheduler;
  localparam int VOICES = 4;
  localparam int TDIV   = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_on;
  logic [1:0]  req_voice;
  logic [6:0]  req_note;
  logic        rom_ce, rom_oce;
  logic [6:0]  rom_ad;
  logic [15:0] rom_dout = 16'd0;
  logic [3:0]  wave, voice_active;
  logic [2:0]  mix;

  logic [15:0] rom [128];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  note_voice_scheduler #(.VOICES(VOICES), .TICK_DIV(TDIV)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_on(req_on), .req_voice(req_voice), .req_note(req_note),
    .rom_ce(rom_ce), .rom_oce(rom_oce), .rom_ad(rom_ad), .rom_dout(rom_dout),
    .wave(wave), .voice_active(voice_active), .mix(mix)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Production period table: half-period in 100 kHz ticks, round(50000 / f_note).
  initial begin
    for (int n = 0; n < 128; n++) begin
      real f;
      f = 440.0 * $pow(2.0, (n - 69) / 12.0);
      rom[n] = 16'($rtoi(50000.0 / f + 0.5));
    end
  end
  always @(posedge clk) if (rom_ce && rom_oce) rom_dout <= rom[rom_ad];

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       rst, vld, on;
    logic [1:0] voice;
    logic [6:0] note;
    logic       exp_ready, exp_ce;
    logic [6:0] exp_ad;
    logic [3:0] exp_act;
    logic [3:0] exp_wave;
    logic [2:0] exp_mix;
  } vec_t;

  function automatic vec_t mk(bit rst, bit vld, bit on, int v, int n,
                              bit rdy, bit ce, int ad, int act);
    vec_t r;
    r.rst = rst; r.vld = vld; r.on = on; r.voice = 2'(v); r.note = 7'(n);
    r.exp_ready = rdy; r.exp_ce = ce; r.exp_ad = 7'(ad); r.exp_act = 4'(act);
    r.exp_wave = 4'd0; r.exp_mix = 3'd0;
    return r;
  endfunction

  function automatic int pc(logic [3:0] w);
    return int'(w[0]) + int'(w[1]) + int'(w[2]) + int'(w[3]);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_toggle(input int v, input int budget, output int t);
    logic w0;
    w0 = wave[v];
    t = -1;
    for (int i = 0; i < budget; i++) begin
      step();
      if (wave[v] != w0) begin
        t = cyc;
        return;
      end
    end
  endtask

  task automatic note_on(input int v, input int n);
    req_valid = 1'b1; req_on = 1'b1; req_voice = 2'(v); req_note = 7'(n);
    #1 chk("note_on_ready", int'(req_ready), 1);
    step();
    req_valid = 1'b0;
  endtask

  vec_t tbl[20];
  int   t0, t1, t2, tl, mm;
  int   last[4], ival[4];
  logic [3:0] prev;
  int   exp_ival[4] = '{191 * TDIV, 152 * TDIV, 128 * TDIV, 96 * TDIV};

  initial begin
    tbl[0]  = mk(1,1,1,1,69, 0,0,0,0);
    tbl[1]  = mk(1,1,1,1,69, 0,0,0,0);
    tbl[2]  = mk(1,1,1,1,69, 0,0,0,0);
    tbl[3]  = mk(0,1,1,1,69, 1,1,69,0);
    tbl[4]  = mk(0,0,0,0,0,  0,0,69,0);
    tbl[5]  = mk(0,0,0,0,0,  0,0,69,2);
    tbl[6]  = mk(0,0,0,0,0,  1,0,69,2);
    tbl[7]  = mk(0,1,1,0,60, 1,1,60,2);
    tbl[8]  = mk(0,1,1,1,64, 0,0,60,2);
    tbl[9]  = mk(0,1,1,1,64, 0,0,60,3);
    tbl[10] = mk(0,1,1,1,64, 1,1,64,3);
    tbl[11] = mk(0,1,1,2,67, 0,0,64,3);
    tbl[12] = mk(0,1,1,2,67, 0,0,64,3);
    tbl[13] = mk(0,1,1,2,67, 1,1,67,3);
    tbl[14] = mk(0,1,1,3,72, 0,0,67,3);
    tbl[15] = mk(0,1,1,3,72, 0,0,67,7);
    tbl[16] = mk(0,1,1,3,72, 1,1,72,7);
    tbl[17] = mk(0,0,0,0,0,  0,0,72,7);
    tbl[18] = mk(0,0,0,0,0,  0,0,72,15);
    tbl[19] = mk(0,0,0,0,0,  1,0,72,15);

    reset = 1'b1; req_valid = 1'b0; req_on = 1'b0; req_voice = 2'd0; req_note = 7'd0;
    for (int i = 0; i < 20; i++) begin
      reset = tbl[i].rst; req_valid = tbl[i].vld; req_on = tbl[i].on;
      req_voice = tbl[i].voice; req_note = tbl[i].note;
      #1 chk($sformatf("v%0d_ready", i), int'(req_ready), int'(tbl[i].exp_ready));
      step();
      chk($sformatf("v%0d_rom_ce", i),  int'(rom_ce),       int'(tbl[i].exp_ce));
      chk($sformatf("v%0d_rom_oce", i), int'(rom_oce),      int'(tbl[i].exp_ce));
      chk($sformatf("v%0d_rom_ad", i),  int'(rom_ad),       int'(tbl[i].exp_ad));
      chk($sformatf("v%0d_active", i),  int'(voice_active), int'(tbl[i].exp_act));
      chk($sformatf("v%0d_wave", i),    int'(wave),         int'(tbl[i].exp_wave));
      chk($sformatf("v%0d_mix", i),     int'(mix),          int'(tbl[i].exp_mix));
    end
    req_valid = 1'b0;

    chk("per0_note60", int'(dut.per[0]), 191);
    chk("per1_note64", int'(dut.per[1]), 152);
    chk("per2_note67", int'(dut.per[2]), 128);
    chk("per3_note72", int'(dut.per[3]), 96);

    // Four voices free-running: toggle intervals and one-cycle mix lag.
    mm = 0;
    prev = wave;
    for (int v = 0; v < 4; v++) begin last[v] = -1; ival[v] = -1; end
    for (int i = 0; i < 2000; i++) begin
      step();
      if (int'(mix) != pc(prev)) mm++;
      for (int v = 0; v < 4; v++)
        if (wave[v] != prev[v]) begin
          if (last[v] >= 0) ival[v] = cyc - last[v];
          last[v] = cyc;
        end
      prev = wave;
    end
    chk("mix_lag_mismatches", mm, 0);
    for (int v = 0; v < 4; v++) chk($sformatf("toggle_ival_v%0d", v), ival[v], exp_ival[v]);

    // Note-off on voice 2 while its wave is high, then voice 3 the very next cycle.
    t0 = -1;
    for (int i = 0; i < 1000 && t0 < 0; i++) begin
      if (wave[2]) t0 = cyc;
      else step();
    end
    chk("off_found_high", int'(t0 >= 0), 1);
    req_valid = 1'b1; req_on = 1'b0; req_voice = 2'd2;
    #1 chk("off2_ready", int'(req_ready), 1);
    step();
    chk("off2_wave", int'(wave[2]), 0);
    chk("off2_active", int'(voice_active[2]), 0);
    chk("off2_cnt", int'(dut.cnt[2]), 0);
    req_voice = 2'd3;
    #1 chk("off3_ready", int'(req_ready), 1);
    step();
    chk("off3_active", int'(voice_active), 4'b0011);
    req_voice = 2'd2;
    step();
    req_valid = 1'b0;
    chk("off_inactive", int'(voice_active), 4'b0011);
    chk("off_inactive_wave", int'(wave[3:2]), 0);

    // Line up the LOAD edge with a tick edge for active voice 0 (note 127, per 4).
    for (int i = 0; i < 8 && dut.tick_cnt != 2'd1; i++) step();
    chk("collide_align", int'(dut.tick_cnt), 1);
    note_on(0, 127);
    step();
    chk("collide_tick_high", int'(dut.tick), 1);
    step();
    tl = cyc;
    chk("collide_cnt", int'(dut.cnt[0]), 4);
    chk("collide_per", int'(dut.per[0]), 4);
    chk("collide_wave", int'(wave[0]), 0);
    chk("collide_active", int'(voice_active[0]), 1);
    wait_toggle(0, 100, t1);
    chk("n127_first_toggle", t1 - tl, 16);
    wait_toggle(0, 100, t2);
    chk("n127_toggle_ival", t2 - t1, 16);

    // Table low extreme on voice 3.
    note_on(3, 0);
    step(); step();
    chk("n0_per", int'(dut.per[3]), 16'h17E4);
    chk("n0_active", int'(voice_active[3]), 1);

    // Note 69 retrigger on voice 1.
    note_on(1, 69);
    chk("n69_rom_ce", int'(rom_ce), 1);
    chk("n69_rom_ad", int'(rom_ad), 69);
    step(); step();
    chk("n69_per", int'(dut.per[1]), 16'h0072);
    chk("n69_active", int'(voice_active), 4'b1011);
    wait_toggle(1, 1000, t0);
    wait_toggle(1, 1000, t1);
    wait_toggle(1, 1000, t2);
    chk("n69_half", t1 - t0, 456);
    chk("n69_period", t2 - t0, 912);

    // Reset during READ abandons the lookup.
    note_on(2, 60);
    chk("abort_rom_ce_read", int'(rom_ce), 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_rom_ce", int'(rom_ce), 0);
    chk("abort_active", int'(voice_active), 0);
    chk("abort_per2", int'(dut.per[2]), 0);
    step(); step(); step();
    chk("abort_active_late", int'(voice_active), 0);
    chk("abort_per2_late", int'(dut.per[2]), 0);
    chk("abort_ready", int'(req_ready), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
